// File: rtl/mac_operand_fifo.sv
// Operand-pair FIFO feeding vectored_mac: issues one (A,B) pair per cycle,
// then after VEC_LEN pairs drains for DRAIN_CYC cycles and pulses Clr/vec_done.
module mac_operand_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int VEC_LEN    = 8,
   parameter int DRAIN_CYC  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   A_in,
   input  logic [DATA_WIDTH-1:0]   B_in,
   input  logic                    hold,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    ovf,
   output logic [DATA_WIDTH-1:0]   Ain,
   output logic [DATA_WIDTH-1:0]   Bin,
   output logic                    En,
   output logic                    Clr,
   output logic                    vec_done
);

   localparam int AW  = $clog2(DEPTH);
   localparam int VW  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   localparam logic [1:0] ST_ISSUE = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q, count_d;
   logic [1:0]            state_q, state_d;
   logic [VW-1:0]         vcnt_q, vcnt_d;
   logic [DCW-1:0]        dcnt_q, dcnt_d;
   logic [DATA_WIDTH-1:0] ain_q, ain_d;
   logic [DATA_WIDTH-1:0] bin_q, bin_d;
   logic                  en_q, en_d;
   logic                  ovf_q, ovf_d;
   logic                  wr_acc;
   logic                  pop;
   logic                  full_w;
   logic                  empty_w;

   // Occupancy flags come from the counter, so a full FIFO with equal pointers is unambiguous.
   assign full_w  = (count_q == (AW+1)'(DEPTH));
   assign empty_w = (count_q == '0);

   always_comb begin
      wr_acc   = wr_en && !full_w;
      pop      = (state_q == ST_ISSUE) && !empty_w && !hold;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      state_d  = state_q;
      vcnt_d   = vcnt_q;
      dcnt_d   = dcnt_q;
      ain_d    = ain_q;
      bin_d    = bin_q;
      en_d     = 1'b0;
      ovf_d    = ovf_q | (wr_en & full_w);

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d       = rd_ptr_q + AW'(1);
         {ain_d, bin_d} = mem_q[rd_ptr_q];
         en_d           = 1'b1;
      end

      case ({wr_acc, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         ST_ISSUE: begin
            if (pop) begin
               if (vcnt_q == VW'(VEC_LEN - 1)) begin
                  vcnt_d  = '0;
                  state_d = ST_DRAIN;
               end else begin
                  vcnt_d = vcnt_q + VW'(1);
               end
            end
         end
         ST_DRAIN: begin
            // The first drain cycle is the one carrying the final En.
            if (dcnt_q == DCW'(DRAIN_CYC - 1)) begin
               dcnt_d  = '0;
               state_d = ST_CLEAR;
            end else begin
               dcnt_d = dcnt_q + DCW'(1);
            end
         end
         ST_CLEAR: state_d = ST_ISSUE;
         default:  state_d = ST_ISSUE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= {A_in, B_in};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_ISSUE;
         vcnt_q   <= '0;
         dcnt_q   <= '0;
         ain_q    <= '0;
         bin_q    <= '0;
         en_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         vcnt_q   <= vcnt_d;
         dcnt_q   <= dcnt_d;
         ain_q    <= ain_d;
         bin_q    <= bin_d;
         en_q     <= en_d;
         ovf_q    <= ovf_d;
      end
   end

   assign full     = full_w;
   assign empty    = empty_w;
   assign count    = count_q;
   assign ovf      = ovf_q;
   assign Ain      = ain_q;
   assign Bin      = bin_q;
   assign En       = en_q;
   assign Clr      = (state_q == ST_CLEAR);
   assign vec_done = (state_q == ST_CLEAR);

endmodule

// File: doc/mac_operand_fifo.md
Name: mac_operand_fifo

Overview:
Upstream feeder for vectored_mac. Buffers (A,B) operand pairs in a DEPTH-entry FIFO and issues them one pair per cycle on Ain/Bin with En. After VEC_LEN pairs it waits a programmable drain interval, then pulses Clr to the MAC. vec_done marks the single cycle in which the completed dot product on Cout is valid.

Parameters:
DATA_WIDTH, 8, operand width; matches vectored_mac DATA_WIDTH.
DEPTH, 8, FIFO entries; power of two, >=2.
VEC_LEN, 8, pairs per dot product; >=1.
DRAIN_CYC, 2, idle cycles after the last issued pair before Clr; >=1, covers MAC accumulate latency.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write request for pair A_in/B_in
A_in  input  DATA_WIDTH  operand A to enqueue
B_in  input  DATA_WIDTH  operand B to enqueue
hold  input  1  1 = suspend issue; does not affect writes
full  output  1  count==DEPTH
empty  output  1  count==0
count  output  $clog2(DEPTH)+1  current occupancy
ovf  output  1  sticky: write attempted while full
Ain  output  DATA_WIDTH  to MAC Ain
Bin  output  DATA_WIDTH  to MAC Bin
En  output  1  to MAC En; Ain/Bin valid
Clr  output  1  to MAC Clr
vec_done  output  1  Cout holds the finished dot product this cycle

Behaviour:
- Reset (asynchronous, immediate): pointers=0, count=0, state=ISSUE, vector counter=0, drain counter=0. Ain=0, Bin=0, En=0, Clr=0, vec_done=0, ovf=0, empty=1, full=0. FIFO contents are discarded.
- Write: accepted at an edge if wr_en && !full, where full is evaluated before that edge. A pop in the same cycle does not make room for a write in that cycle. wr_en && full drops the data and sets ovf; ovf is cleared only by rst.
- Pop condition at an edge: state==ISSUE && !empty && !hold. There is no fall-through: a pair written at edge t can be popped at edge t+1 at the earliest.
- Issue timing: a pop at edge e registers Ain/Bin from the head entry. En=1 during the cycle after e. When no pop occurs, En=0 and Ain/Bin hold their last values.
- Simultaneous write and pop: count is unchanged. Write into an empty FIFO: count goes 0->1, no pop that edge.
- Pointers wrap modulo DEPTH. full and empty are derived from count, never from pointer equality alone.
- Vector counter: 0..VEC_LEN-1, incremented per pop only. Cycles where hold or empty block a pop do not advance it.
- State machine:
  - ISSUE: pops allowed. If the pop makes the VEC_LEN-th pair, go to DRAIN in the same edge and reset the vector counter to 0.
  - DRAIN: lasts exactly DRAIN_CYC cycles, starting with the cycle in which the last En is high; no pops; then go to CLEAR.
  - CLEAR: one cycle; Clr=1 and vec_done=1; no pops; then go to ISSUE.
  - The MAC Cout is sampled by consumers at the end of the CLEAR cycle and is zero afterwards.
- Writes are accepted in every state.
- hold has no effect in DRAIN or CLEAR.
- Clr and En are never both high in the same cycle.
- Widths: count uses $clog2(DEPTH)+1 bits so that DEPTH itself is representable.

Test Plan:
1. Reset, hold=0, write pairs A=1..8, B=2 on consecutive cycles (VEC_LEN=8, DRAIN_CYC=2, MAC attached) -> En high 8 consecutive cycles starting 2 cycles after the first write, Ain=1..8 in order, Bin=2; Clr=vec_done=1 for one cycle, 2 cycles after the first cycle of the last En; Cout=72 in that cycle, 0 the next.
2. hold=1, write 10 pairs (DEPTH=8) -> full=1 and count=8 after the 8th write; ovf=1; pairs 9 and 10 dropped. Release hold -> exactly 8 issued in write order, then empty=1.
3. count=3, wr_en with a pop in the same cycle -> count stays 3. Empty FIFO, single write -> En=0 the next cycle, En=1 the cycle after.
4. hold pulsed high for 3 cycles after the 4th issued pair -> En low exactly those 3 cycles; Clr follows only after the 8th pair; Cout=72.
5. rst asserted mid-vector between edges (after 5 pairs) -> En, Clr, vec_done, Ain, Bin and count go to 0 without a clock edge. After release, a new 8-pair vector produces vec_done only after 8 more pops.
6. Writes during DRAIN/CLEAR -> count increments, En=0 throughout DRAIN-after-last/CLEAR. First En of the next vector appears 2 cycles after the CLEAR cycle.
